// File: rtl/softmax_pkg.sv
// Shared widths and FSM encoding for the softmax write-back path.
package softmax_pkg;

    localparam int FP32_W       = 32;
    localparam int BF16_W       = 16;
    localparam int LANES        = 4;
    localparam int DATA_NUM_DEF = 192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fp32_to_bf16.sv
// One-lane fp32 -> bf16 narrowing. Truncates by default; `SOFTMAX_PACK_RNE_EN selects
// round-to-nearest-even with quiet-NaN canonicalisation.
module fp32_to_bf16
    import softmax_pkg::*;
(
    input  logic [FP32_W-1:0] i_f,
    output logic [BF16_W-1:0] o_h
);

`ifdef SOFTMAX_PACK_RNE_EN
    logic w_nan;
    logic w_inc;

    assign w_nan = (i_f[30:23] == 8'hFF) && (i_f[22:0] != 23'd0);
    // Inf has an all-zero mantissa, so it never rounds; max finite may carry into Inf.
    assign w_inc = i_f[15] & ((i_f[14:0] != 15'd0) | i_f[16]);
    assign o_h   = w_nan ? {i_f[31], 8'hFF, 7'h40}
                         : i_f[31:16] + {{(BF16_W-1){1'b0}}, w_inc};
`else
    logic w_unused_lo;

    assign w_unused_lo = ^i_f[15:0];
    assign o_h         = i_f[31:16];
`endif

endmodule

// File: rtl/softmax_result_packer.sv
// Softmax write-back: narrows 4x fp32 beats to bf16, buffers them in a skid FIFO and writes
// one 64b word per beat at base_addr + index. Rounding mode chosen by `SOFTMAX_PACK_RNE_EN.
module softmax_result_packer
    import softmax_pkg::*;
#(
    parameter int DATA_NUM   = DATA_NUM_DEF,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stage_start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      in_tvalid,
    input  logic [LANES*FP32_W-1:0]   in_tdata,
    output logic                      mem_wr_en,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic [LANES*BF16_W-1:0]   mem_wr_data,
    input  logic                      mem_wr_ready,
    output logic                      done,
    output logic                      overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_NUM + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_NUM);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(DATA_NUM - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);

    state_e                          r_state;
    logic                            r_start_d;
    logic [ADDR_W-1:0]               r_base;
    logic [CNT_W-1:0]                r_in_cnt;
    logic [ADDR_W-1:0]               r_wr_cnt;
    logic                            r_ovf;
    logic [LANES*BF16_W-1:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W:0]                  r_wptr;
    logic [PTR_W:0]                  r_rptr;

    logic [LANES-1:0][BF16_W-1:0]    w_bf;
    logic                            w_busy;
    logic                            w_rise;
    logic                            w_abort;
    logic                            w_arm;
    logic                            w_empty;
    logic                            w_full;
    logic                            w_pop;
    logic                            w_beat;
    logic                            w_push;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp32_to_bf16 u_cvt (
            .i_f (in_tdata[g*FP32_W +: FP32_W]),
            .o_h (w_bf[g])
        );
    end

    assign w_busy  = (r_state == RUN) || (r_state == DRAIN);
    assign w_rise  = stage_start & ~r_start_d;
    assign w_abort = w_busy & ~stage_start;
    assign w_arm   = w_rise & ((r_state == IDLE) || (r_state == DONE));

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

    assign w_pop   = mem_wr_en & mem_wr_ready;
    // Beats in the abort cycle are discarded without touching overflow.
    assign w_beat  = (r_state == RUN) & stage_start & in_tvalid;
    assign w_push  = w_beat & (~w_full | w_pop);

    assign mem_wr_en   = w_busy & ~w_empty;
    assign mem_wr_addr = r_base + r_wr_cnt;
    assign mem_wr_data = r_mem[r_rptr[PTR_W-1:0]];
    assign done        = (r_state == DONE);
    assign overflow    = r_ovf;

    // Storage is reset so mem_wr_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_arm || w_abort) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PTR_W-1:0]] <= w_bf;
                r_wptr                   <= r_wptr + PTR_ONE;
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
            r_base    <= '0;
            r_in_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_start_d <= stage_start;
            if (w_pop) r_wr_cnt <= r_wr_cnt + ADDR_ONE;
            if (w_arm) begin
                r_state  <= RUN;
                r_base   <= base_addr;
                r_in_cnt <= '0;
                r_wr_cnt <= '0;
                r_ovf    <= 1'b0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (!stage_start) begin
                            r_state <= IDLE;
                        end else if (w_beat) begin
                            r_in_cnt <= r_in_cnt + CNT_ONE;
                            if (r_in_cnt == CNT_PRE) r_state <= DRAIN;
                            if (!w_push) r_ovf <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!stage_start)                           r_state <= IDLE;
                        else if (w_empty && r_in_cnt == CNT_LAST)   r_state <= DONE;
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_softmax_result_packer.sv
// Randomized bench for softmax_result_packer against a queue-based reference model.
module tb_softmax_result_packer;

    localparam int DN    = 192;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stage_start;
    logic [15:0]  base_addr;
    logic         in_tvalid;
    logic [127:0] in_tdata;
    logic         mem_wr_en;
    logic [15:0]  mem_wr_addr;
    logic [63:0]  mem_wr_data;
    logic         mem_wr_ready;
    logic         done;
    logic         overflow;

    softmax_result_packer #(.DATA_NUM(DN), .ADDR_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stage_start(stage_start), .base_addr(base_addr),
        .in_tvalid(in_tvalid), .in_tdata(in_tdata), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bf(input logic [31:0] f);
        int unsigned hi;
        hi = f >> 16;
`ifdef SOFTMAX_PACK_RNE_EN
        begin
            int unsigned lo;
            lo = f & 32'hFFFF;
            if (((f >> 23) & 32'hFF) == 32'hFF && (f & 32'h7F_FFFF) != 0)
                return {f[31], 15'h7FC0};
            if (lo > 32'h8000 || (lo == 32'h8000 && hi % 2 == 1)) hi = hi + 1;
        end
`endif
        return hi[15:0];
    endfunction

    function automatic logic [63:0] cvt4(input logic [127:0] d);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = bf(d[32*i +: 32]);
        return r;
    endfunction

    // Reference model: a row is active from arm until all DN beats are in and written out.
    logic [63:0] q[$];
    bit          m_active, m_done, m_ovf, m_prev;
    logic [15:0] m_base;
    int          m_in, m_wr, m_drops;

    logic [15:0] hs_addr[$];
    logic [63:0] hs_data[$];
    int          done_cnt = 0;

    initial begin
        bit rise;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_en", mem_wr_en, 0);
                chk("rst_done", done, 0);
                chk("rst_ovf", overflow, 0);
            end else begin
                chk("wr_en", mem_wr_en, (m_active && q.size() > 0));
                if (m_active && q.size() > 0) begin
                    chk("wr_addr", mem_wr_addr, 16'(m_base + m_wr));
                    chk("wr_data", mem_wr_data, q[0]);
                end
                chk("done", done, m_done);
                chk("overflow", overflow, m_ovf);
                if (mem_wr_en && mem_wr_ready) begin
                    hs_addr.push_back(mem_wr_addr);
                    hs_data.push_back(mem_wr_data);
                end
                if (done) done_cnt++;
            end
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                m_active = 0; m_done = 0; m_ovf = 0; m_prev = 0;
            end else begin
                rise = stage_start && !m_prev;
                if (m_done || !m_active) begin
                    m_done = 0;
                    if (rise) begin
                        m_active = 1; m_base = base_addr; m_in = 0; m_wr = 0;
                        m_ovf = 0; m_drops = 0; q.delete();
                    end
                end else if (!stage_start) begin
                    m_active = 0; q.delete();
                end else if (m_in == DN && q.size() == 0) begin
                    m_active = 0; m_done = 1;
                end else begin
                    if (q.size() > 0 && mem_wr_ready) begin
                        void'(q.pop_front());
                        m_wr++;
                    end
                    if (m_in < DN && in_tvalid) begin
                        m_in++;
                        if (q.size() < DEPTH) q.push_back(cvt4(in_tdata));
                        else begin m_ovf = 1; m_drops++; end
                    end
                end
                m_prev = stage_start;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [15:0] b);
        base_addr = b;
        stage_start = 0;
        tick();
        stage_start = 1;
        hs_addr.delete();
        hs_data.delete();
        tick();
    endtask

    // dmode 0: fixed 1.0/1.5/2.0/3.0 lanes, else random. rmode 0: ready, 1: 20-cycle stall, 2: random.
    task automatic send_row(input int n, input int dmode, input int vpct, input int rmode);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 5000) begin
            in_tvalid = ($urandom_range(99) < vpct);
            in_tdata  = (dmode == 0) ? 128'h4040_0000_4000_0000_3FC0_0000_3F80_0000
                                     : {$urandom, $urandom, $urandom, $urandom};
            case (rmode)
                0:       mem_wr_ready = 1;
                1:       mem_wr_ready = !(cyc >= 60 && cyc < 80);
                default: mem_wr_ready = ($urandom_range(3) != 0);
            endcase
            tick();
            if (in_tvalid) sent++;
            cyc++;
        end
        in_tvalid = 0;
        mem_wr_ready = 1;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 1000) begin
            tick();
            k++;
        end
        chk("done_seen", done_cnt != d0, 1);
        repeat (3) tick();
        chk("done_once", done_cnt - d0, 1);
    endtask

    logic [31:0] conv_in  [4] = '{32'h3F80_8001, 32'h3F80_8000, 32'h7FC1_2345, 32'hFF80_0000};
`ifdef SOFTMAX_PACK_RNE_EN
    logic [15:0] conv_exp [4] = '{16'h3F81, 16'h3F80, 16'h7FC0, 16'hFF80};
`else
    logic [15:0] conv_exp [4] = '{16'h3F80, 16'h3F80, 16'h7FC1, 16'hFF80};
`endif

    initial begin
        int d0;
        rst_n = 0; stage_start = 0; base_addr = 0; in_tvalid = 0; in_tdata = '0;
        mem_wr_ready = 1;
        repeat (3) tick();
        chk("reset_addr", mem_wr_addr, 0);
        chk("reset_data", mem_wr_data, 0);
        rst_n = 1;
        tick();

        // Back-to-back row, always ready.
        arm(16'h0100);
        send_row(DN, 0, 100, 0);
        wait_done();
        chk("t1_writes", hs_addr.size(), DN);
        chk("t1_first_addr", hs_addr[0], 16'h0100);
        chk("t1_last_addr", hs_addr[DN-1], 16'h01BF);
        chk("t1_data", hs_data[0], 64'h4040_4000_3FC0_3F80);
        chk("t1_ovf", overflow, 0);

        // Memory stall long enough to overrun the FIFO.
        arm(16'h0100);
        send_row(DN, 0, 100, 1);
        wait_done();
        chk("t2_ovf", overflow, 1);
        chk("t2_dropped", m_drops > 0, 1);
        chk("t2_writes", hs_addr.size(), DN - m_drops);
        chk("t2_last_addr", hs_addr[hs_addr.size()-1], 16'(16'h0100 + hs_addr.size() - 1));

        // Conversion corner cases on lane 0.
        arm(16'h0300);
        for (int k = 0; k < 4; k++) begin
            in_tvalid = 1;
            in_tdata  = {$urandom, $urandom, $urandom, conv_in[k]};
            tick();
        end
        in_tvalid = 0;
        repeat (3) tick();
        chk("conv_writes", hs_data.size(), 4);
        for (int k = 0; k < 4 && k < hs_data.size(); k++)
            chk($sformatf("conv_%0d", k), hs_data[k][15:0], conv_exp[k]);

        // Abort mid-row with a partly full FIFO, then re-arm.
        arm(16'h0400);
        send_row(50, 1, 100, 2);
        mem_wr_ready = 0;
        in_tvalid = 1;
        tick();
        in_tvalid = 0;
        d0 = done_cnt;
        stage_start = 0;
        tick();
        chk("abort_en", mem_wr_en, 0);
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        mem_wr_ready = 1;
        arm(16'h0200);
        send_row(DN, 1, 80, 2);
        wait_done();
        chk("t5_first_addr", hs_addr[0], 16'h0200);
        chk("t5_writes", hs_addr.size(), DN - m_drops);

        // Address wrap.
        arm(16'hFFF0);
        send_row(DN, 1, 100, 0);
        wait_done();
        chk("wrap_writes", hs_addr.size(), DN);
        chk("wrap_ffff", hs_addr[15], 16'hFFFF);
        chk("wrap_zero", hs_addr[16], 16'h0000);

        // Asynchronous reset in the middle of a row.
        arm(16'h0500);
        send_row(30, 1, 100, 0);
        #2;
        rst_n = 0;
        #1;
        chk("arst_en", mem_wr_en, 0);
        chk("arst_addr", mem_wr_addr, 0);
        chk("arst_data", mem_wr_data, 0);
        chk("arst_done", done, 0);
        chk("arst_ovf", overflow, 0);
        stage_start = 0;
        tick();
        tick();
        rst_n = 1;
        repeat (3) tick();
        chk("post_rst_en", mem_wr_en, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
